// File: rtl/imem_loader_if.sv
// Source-stream and instruction-memory write bus of the loader.
//   in_valid/in_data/in_ready : word stream from the source (valid/ready)
//   mem_we/mem_addr/mem_wdata : registered write port into instruction memory
// master: the side feeding words and observing writes (source / memory)
// slave : the loader itself
interface imem_loader_if #(parameter int ADDR_W = 6);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (output in_valid, in_data,
                  input  in_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input  in_valid, in_data,
                  output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: streams word_count words (clamped to DEPTH)
// from a valid/ready source into instruction memory at addresses 0..N-1,
// keeping the CPU held in reset until the first load completes.
//   clk, reset      : clock, async active-low reset
//   start           : begin a load (sampled in IDLE only)
//   word_count      : words to load, sampled with start
//   bus (slave)     : source stream in, memory write port out
//   cpu_hold        : holds fetch/pipeline in reset while high
//   busy            : high while loading
//   done            : one-cycle completion pulse (coincides with final write)
//   checksum        : XOR of all words accepted in the current/last load
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   index_q, index_d;
  logic [ADDR_W:0]   target_q, target_d;
  logic [31:0]       cks_q, cks_d;
  logic              hold_q, hold_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    target_d = target_q;
    cks_d    = cks_q;
    hold_d   = hold_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;           // strobe only on the cycle after a transfer
    case (state_q)
      IDLE: begin
        if (start) begin
          cks_d  = '0;
          hold_d = 1'b1;
          if (word_count == '0) begin
            state_d = DONE;
          end else begin
            state_d  = LOAD;
            index_d  = '0;
            target_d = (word_count > DEPTH_W) ? DEPTH_W : word_count;
          end
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          we_d    = 1'b1;
          addr_d  = index_q[ADDR_W-1:0];
          wdata_d = bus.in_data;
          cks_d   = cks_q ^ bus.in_data;
          index_d = index_q + ONE;
          // Last word: the write lands while we sit in DONE.
          if (index_q == target_q - ONE) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        hold_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      index_q  <= '0;
      target_q <= '0;
      cks_q    <= '0;
      hold_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      target_q <= target_d;
      cks_q    <= cks_d;
      hold_q   <= hold_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state_q == LOAD);
  assign done          = (state_q == DONE);
  assign cpu_hold      = hold_q;
  assign checksum      = cks_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a transaction-level reference model:
// the model tracks only "words accepted so far / target", the running XOR and
// the expected pending write, and is compared every cycle on the falling edge.
module tb_imem_loader;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              cpu_hold, busy, done;
  logic [31:0]       checksum;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .word_count(word_count),
    .bus(bus), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_we    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: one record per cycle describing what the outputs must be.
  typedef struct {
    bit          loading;
    bit          done;
    bit          hold;
    bit          pend;
    int          acc;
    int          tgt;
    logic [31:0] cks;
    int          paddr;
    logic [31:0] pdata;
  } model_t;

  model_t m = '{loading:0, done:0, hold:1, pend:0, acc:0, tgt:0, cks:0, paddr:0, pdata:0};

  function automatic model_t model_reset();
    model_t r = '{loading:0, done:0, hold:1, pend:0, acc:0, tgt:0, cks:0, paddr:0, pdata:0};
    return r;
  endfunction

  function automatic model_t step(model_t s, bit st, int wc, bit v, logic [31:0] d);
    model_t n = s;
    n.pend = 0;
    n.done = 0;
    if (s.loading) begin
      if (v) begin
        n.pend  = 1;
        n.paddr = s.acc;
        n.pdata = d;
        n.cks   = s.cks ^ d;
        n.acc   = s.acc + 1;
        if (n.acc == s.tgt) begin
          n.loading = 0;
          n.done    = 1;
        end
      end
    end else if (s.done) begin
      n.hold = 0;
    end else if (st) begin
      n.cks  = 0;
      n.hold = 1;
      if (wc == 0) n.done = 1;
      else begin
        n.loading = 1;
        n.acc     = 0;
        n.tgt     = (wc > DEPTH) ? DEPTH : wc;
      end
    end
    return n;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_we",    {31'd0, bus.mem_we},   32'd0);
      chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_hold",  {31'd0, cpu_hold},     32'd1);
      chk("rst_cks",   checksum,              32'd0);
      m <= model_reset();
    end else begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m.loading});
      chk("busy",     {31'd0, busy},         {31'd0, m.loading});
      chk("done",     {31'd0, done},         {31'd0, m.done});
      chk("cpu_hold", {31'd0, cpu_hold},     {31'd0, m.hold});
      chk("checksum", checksum,              m.cks);
      chk("mem_we",   {31'd0, bus.mem_we},   {31'd0, m.pend});
      if (m.pend) begin
        chk("mem_addr",  {26'd0, bus.mem_addr}, 32'(m.paddr));
        chk("mem_wdata", bus.mem_wdata,         m.pdata);
      end
      if (bus.mem_we) n_we <= n_we + 1;
      m <= step(m, start, int'(word_count), bus.in_valid, bus.in_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input bit v, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    cyc();
  endtask

  task automatic pulse_start(input int wc);
    start      = 1'b1;
    word_count = (ADDR_W+1)'(wc);
    bus.in_valid = 1'b0;
    cyc();
    start = 1'b0;
  endtask

  // Random load; optional spurious start pulses while loading.
  task automatic run_load(input int wc, input int pct, input int max_cyc, input bit restart);
    int n = 0;
    pulse_start(wc);
    while (m.loading && n < max_cyc) begin
      bus.in_valid = ($urandom_range(99) < pct);
      bus.in_data  = $urandom;
      start        = restart && ($urandom_range(3) == 0);
      word_count   = (ADDR_W+1)'($urandom);
      cyc();
      n++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    chk("load_timeout", {31'd0, m.loading}, 32'd0);
    cyc();
    cyc();
  endtask

  logic [31:0] w [4] = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h00000013};
  bit          pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int we0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) cyc();
    reset = 1'b1;
    repeat (3) cyc();

    // Four-word program, back-to-back.
    pulse_start(4);
    for (int i = 0; i < 4; i++) offer(1'b1, w[i]);
    bus.in_valid = 1'b0;
    chk("cks_034",  checksum, 32'h00500093 ^ 32'h00300113 ^ 32'h002081B3 ^ 32'h00000013);
    chk("done_034", {31'd0, done}, 32'd1);
    cyc();
    chk("hold_034", {31'd0, cpu_hold}, 32'd0);
    cyc();

    // Stalled source.
    pulse_start(3);
    for (int i = 0; i < 5; i++) offer(pat[i], $urandom);
    bus.in_valid = 1'b0;
    repeat (2) cyc();

    // Empty load.
    pulse_start(0);
    chk("done_036", {31'd0, done}, 32'd1);
    repeat (2) cyc();

    // Oversized request: clamp to DEPTH, then extra words must be refused.
    we0 = n_we;
    pulse_start(100);
    for (int i = 0; i < 70; i++) offer(1'b1, $urandom);
    bus.in_valid = 1'b0;
    cyc();
    chk("writes_037", 32'(n_we - we0), 32'd64);

    // Reset mid-load after two words.
    pulse_start(5);
    offer(1'b1, $urandom);
    offer(1'b1, $urandom);
    bus.in_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("arst_we",    {31'd0, bus.mem_we},   32'd0);
    chk("arst_addr",  {26'd0, bus.mem_addr}, 32'd0);
    chk("arst_wdata", bus.mem_wdata,         32'd0);
    chk("arst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("arst_busy",  {31'd0, busy},         32'd0);
    chk("arst_done",  {31'd0, done},         32'd0);
    chk("arst_cks",   checksum,              32'd0);
    chk("arst_hold",  {31'd0, cpu_hold},     32'd1);
    bus.in_valid = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    run_load(5, 100, 50, 1'b0);

    // Spurious start during load, then random loads.
    run_load(20, 60, 400, 1'b1);
    for (int k = 0; k < 20; k++)
      run_load($urandom_range(0, 127), $urandom_range(30, 100), 800, 1'b1);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit instruction memory words.
REQ-002 Parameter ADDR_W, default 6, word address width (2^ADDR_W >= DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a load; sampled in IDLE only.
REQ-006 word_count  input  ADDR_W+1  number of words to load, sampled with start.
REQ-007 in_valid  input  1  source presents a word on in_data.
REQ-008 in_data  input  32  instruction word to store.
REQ-009 in_ready  output  1  loader accepts in_data this cycle.
REQ-010 mem_we  output  1  instruction memory write strobe.
REQ-011 mem_addr  output  ADDR_W  word address of the write.
REQ-012 mem_wdata  output  32  data of the write.
REQ-013 cpu_hold  output  1  keeps fetch and pipeline in reset while high.
REQ-014 busy  output  1  high in LOAD.
REQ-015 done  output  1  one-cycle pulse on load completion.
REQ-016 checksum  output  32  XOR of all words accepted in the current or last load.

Function
REQ-017 FSM states SHALL be IDLE, LOAD and DONE.
REQ-018 Handshake: a word transfers on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly when state=LOAD.
REQ-019 IDLE, start=1, word_count!=0: next state LOAD, index<=0, checksum<=0, cpu_hold<=1, target<=min(word_count, DEPTH).
REQ-020 IDLE, start=1, word_count=0: next state DONE, checksum<=0, no memory write.
REQ-021 start SHALL be ignored in LOAD and DONE.
REQ-022 LOAD, per transfer: registered write next cycle (mem_we=1, mem_addr=index, mem_wdata=in_data); index+1; checksum^=in_data.
REQ-023 mem_we SHALL be 0 in every cycle not caused by a transfer in the previous cycle; write latency is exactly 1 cycle.
REQ-024 LOAD, transfer of word index=target-1: next state DONE.
REQ-025 LOAD with in_valid=0: hold state, index and checksum indefinitely (no timeout).
REQ-026 DONE: done=1 for exactly one cycle; the final write occurs in this cycle; next state IDLE.
REQ-027 cpu_hold SHALL fall on the edge leaving DONE and stay low in IDLE until the next accepted start.
REQ-028 word_count>DEPTH SHALL be clamped to DEPTH; excess source words are never accepted (in_ready=0 after DONE).
REQ-029 Addresses SHALL not wrap; the highest address written is target-1.
REQ-030 checksum SHALL hold its value in IDLE and DONE.

Reset
REQ-031 On reset=0, asynchronously: state=IDLE, index=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, in_ready=0, checksum=0, cpu_hold=1.
REQ-032 cpu_hold SHALL remain 1 after reset release until the first load completes.
REQ-033 Reset asserted mid-LOAD SHALL abort the load; a pending registered write SHALL be dropped.

Verification
REQ-034 Reset release, start=1 with word_count=4, words 0x00500093, 0x00300113, 0x002081B3, 0x00000013 sent back-to-back -> writes to addr 0..3 on cycles 1..4 after each transfer; done on the last-write cycle; checksum = XOR of the four words; cpu_hold low the next cycle.
REQ-035 word_count=3 with in_valid toggling 1,0,0,1,1 -> exactly 3 writes at addr 0,1,2; no write on stall cycles; busy high throughout.
REQ-036 word_count=0 -> done pulse 1 cycle after start; no mem_we; checksum=0; cpu_hold falls after done.
REQ-037 DEPTH=64, word_count=100, 70 words offered -> 64 writes (addr 0..63); in_ready low after the 64th transfer; words 65..70 not accepted.
REQ-038 reset pulled low after 2 of 5 words -> all outputs at reset values immediately; cpu_hold=1; a new start/load then proceeds from addr 0.
REQ-039 start pulsed again during LOAD -> ignored; index and checksum continue unaffected.
